// File: rtl/eeg_patch_loader_pkg.sv
// -----------------------------------------------------------------------------
// eeg_patch_loader_pkg
// Shared definitions for the EEG patch loader: epoch geometry, the memory-map
// base of the EEG input region, intermediate-result address/data types, the
// loader state encoding and the ADC-sample centring helper.
// -----------------------------------------------------------------------------
package eeg_patch_loader_pkg;

  // Epoch geometry: patches per sleep epoch and samples per patch.
  localparam int unsigned NUM_PATCHES_DEF = 60;
  localparam int unsigned PATCH_LEN_DEF   = 64;

  // Fixed-point alignment of a centred 16-bit sample to the EEG input format.
  localparam int unsigned FRAC_SHIFT_DEF  = 4;

  // Memory map: start of the EEG input region in intermediate-result memory.
  localparam int unsigned EEG_IN_BASE_ADDR = 32'h0000_0000;

  // Intermediate-result memory address and computation fixed-point word.
  typedef logic        [15:0] IntResAddr_t;
  typedef logic signed [21:0] CompFx_t;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_e;

  // Convert an unsigned ADC sample (midscale 0x8000) to a signed value centred
  // on zero. Flipping the MSB is exact over the whole range, so no saturation.
  function automatic logic signed [15:0] centre_sample(input logic [15:0] raw);
    return signed'(raw ^ 16'h8000);
  endfunction

endpackage : eeg_patch_loader_pkg

// File: rtl/eeg_patch_loader_if.sv
// -----------------------------------------------------------------------------
// eeg_patch_loader_if
// Bundles the loader's two data paths:
//   sample stream : sample_valid, sample_data (in), sample_ready (out)
//   memory write  : mem_wr_en, mem_wr_addr, mem_wr_data (out), mem_wr_gnt (in)
// Modports:
//   master : the loader (consumes samples, issues memory writes)
//   slave  : the environment (ADC front end + memory arbiter)
// -----------------------------------------------------------------------------
interface eeg_patch_loader_if
  import eeg_patch_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = $bits(IntResAddr_t),
  parameter int unsigned DATA_W = $bits(CompFx_t)
);

  logic                     sample_valid;
  logic [15:0]              sample_data;
  logic                     sample_ready;
  logic                     mem_wr_en;
  logic [ADDR_W-1:0]        mem_wr_addr;
  logic signed [DATA_W-1:0] mem_wr_data;
  logic                     mem_wr_gnt;

  modport master (
    input  sample_valid,
    input  sample_data,
    input  mem_wr_gnt,
    output sample_ready,
    output mem_wr_en,
    output mem_wr_addr,
    output mem_wr_data
  );

  modport slave (
    output sample_valid,
    output sample_data,
    output mem_wr_gnt,
    input  sample_ready,
    input  mem_wr_en,
    input  mem_wr_addr,
    input  mem_wr_data
  );

endinterface : eeg_patch_loader_if

// File: rtl/eeg_patch_loader.sv
// -----------------------------------------------------------------------------
// eeg_patch_loader
// Streams one sleep epoch of ADC samples (NUM_PATCHES x PATCH_LEN) into the
// EEG input region of the intermediate-result memory. Each accepted sample is
// centred, aligned by FRAC_SHIFT and written at BASE_ADDR + p*PATCH_LEN + s
// through a single registered write slot arbitrated by mem_wr_gnt.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : synchronous active-low reset
//   start          : one-cycle pulse starting an epoch load
//   bus (master)   : sample stream in, memory write request out
//   busy           : loader in LOADING or DRAIN
//   epoch_ready    : one-cycle pulse after the last write of the epoch
//   err_start_busy : sticky, start seen while busy
// -----------------------------------------------------------------------------
module eeg_patch_loader
  import eeg_patch_loader_pkg::*;
#(
  parameter int unsigned NUM_PATCHES = NUM_PATCHES_DEF,
  parameter int unsigned PATCH_LEN   = PATCH_LEN_DEF,
  parameter int unsigned ADDR_W      = $bits(IntResAddr_t),
  parameter int unsigned DATA_W      = $bits(CompFx_t),
  parameter int unsigned FRAC_SHIFT  = FRAC_SHIFT_DEF,
  parameter int unsigned BASE_ADDR   = EEG_IN_BASE_ADDR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  eeg_patch_loader_if.master  bus,
  output logic                busy,
  output logic                epoch_ready,
  output logic                err_start_busy
);

  // PATCH_LEN is a power of two, so p*PATCH_LEN is a left shift by LOG2_LEN.
  localparam int unsigned LOG2_LEN = $clog2(PATCH_LEN);
  localparam int unsigned S_W      = (LOG2_LEN > 0) ? LOG2_LEN : 1;
  // p must be able to count one past the last patch without wrapping.
  localparam int unsigned P_W      = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES + 1) : 1;

  localparam logic [S_W-1:0] S_LAST = S_W'(PATCH_LEN - 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(NUM_PATCHES - 1);

  loader_state_e            state_r;
  loader_state_e            state_next_s;

  logic [S_W-1:0]           s_r;
  logic [P_W-1:0]           p_r;

  logic                     wr_en_r;
  logic [ADDR_W-1:0]        wr_addr_r;
  logic signed [DATA_W-1:0] wr_data_r;
  logic                     err_r;

  logic                     ready_s;
  logic                     accept_s;
  logic                     grant_s;
  logic                     last_s;
  logic                     busy_s;
  logic                     start_load_s;
  logic [ADDR_W-1:0]        addr_s;
  logic signed [15:0]       centred_s;
  logic signed [DATA_W-1:0] data_s;

  // A new sample may enter only when the write slot is empty or draining now.
  assign ready_s      = (state_r == ST_LOADING) && (!wr_en_r || bus.mem_wr_gnt);
  assign accept_s     = bus.sample_valid && ready_s;
  assign grant_s      = wr_en_r && bus.mem_wr_gnt;
  assign last_s       = (p_r == P_LAST) && (s_r == S_LAST);
  assign busy_s       = (state_r == ST_LOADING) || (state_r == ST_DRAIN);
  assign start_load_s = (state_r == ST_IDLE) && start;

  // Address of the sample being accepted; truncation to ADDR_W is intended.
  assign addr_s = ADDR_W'(BASE_ADDR) + (ADDR_W'(p_r) << LOG2_LEN) + ADDR_W'(s_r);

  // Sign-extend the centred sample, then align it to the fixed-point format.
  assign centred_s = centre_sample(bus.sample_data);
  assign data_s    = DATA_W'(centred_s) <<< FRAC_SHIFT;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LOADING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOADING: begin
        if (accept_s && last_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_LOADING;
        end
      end
      ST_DRAIN: begin
        // In DRAIN the only pending write is the epoch's last sample.
        if (grant_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sample index s and patch index p; s wraps per patch and carries into p.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_r <= '0;
      p_r <= '0;
    end else if (start_load_s) begin
      s_r <= '0;
      p_r <= '0;
    end else if (accept_s) begin
      if (s_r == S_LAST) begin
        s_r <= '0;
        p_r <= p_r + P_W'(1'b1);
      end else begin
        s_r <= s_r + S_W'(1'b1);
        p_r <= p_r;
      end
    end else begin
      s_r <= s_r;
      p_r <= p_r;
    end
  end

  // Single write slot: loaded on accept, held until granted, then released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else if (accept_s) begin
      wr_en_r   <= 1'b1;
      wr_addr_r <= addr_s;
      wr_data_r <= data_s;
    end else if (grant_s) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= wr_addr_r;
      wr_data_r <= wr_data_r;
    end else begin
      wr_en_r   <= wr_en_r;
      wr_addr_r <= wr_addr_r;
      wr_data_r <= wr_data_r;
    end
  end

  // Sticky protocol error: start while an epoch is in flight (not in DONE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start && busy_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.sample_ready = ready_s;
  assign bus.mem_wr_en    = wr_en_r;
  assign bus.mem_wr_addr  = wr_addr_r;
  assign bus.mem_wr_data  = wr_data_r;
  assign busy             = busy_s;
  assign epoch_ready      = (state_r == ST_DONE);
  assign err_start_busy   = err_r;

endmodule : eeg_patch_loader
